// File: rtl/regfile_write_arbiter_if.sv
// Write-request channel into the register-file write arbiter.
// One instance per requester: valid/addr/data out, ready back.
interface regfile_write_arbiter_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [N-1:0]      data;
  logic              ready;

  modport master (
    output valid, addr, data,
    input  ready
  );

  modport slave (
    input  valid, addr, data,
    output ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between A and B.
// Optional macro RF_ARB_STATS_EN adds the saturating conflict counter.
module regfile_write_arbiter #(
  parameter int N      = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave a,
  regfile_write_arbiter_if.slave b,
  output logic [NREG-1:0]        reg_enable,
  output logic [N-1:0]           reg_wdata,
  output logic                   last_grant,
  output logic [15:0]            conflict_count
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e             prio_q, prio_d;
  logic              gnt_a, gnt_b, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [N-1:0]      sel_data;
  logic [NREG-1:0]   en_d, en_q;
  logic [N-1:0]      wdata_d, wdata_q;
  logic              last_d, last_q;

  // Grant: lone requester wins, contention resolved by prio
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      (a.valid && b.valid): begin
        if (prio_q == PRIO_A) gnt_a = 1'b1;
        else                  gnt_b = 1'b1;
      end
      (a.valid && !b.valid): gnt_a = 1'b1;
      (!a.valid && b.valid): gnt_b = 1'b1;
      default: ;
    endcase
  end

  assign a.ready = gnt_a;
  assign b.ready = gnt_b;
  assign xfer    = gnt_a | gnt_b;

  // Next prio and staged write; x0 never raises an enable
  always_comb begin
    prio_d   = prio_q;
    sel_addr = gnt_b ? b.addr : a.addr;
    sel_data = gnt_b ? b.data : a.data;
    en_d     = '0;
    wdata_d  = wdata_q;
    last_d   = last_q;
    if (xfer) begin
      prio_d  = gnt_a ? PRIO_B : PRIO_A;
      wdata_d = sel_data;
      last_d  = gnt_b;
      for (int i = 1; i < NREG; i++) begin
        en_d[i] = (sel_addr == ADDR_W'(i));
      end
    end
  end

  // State and output stage; reset drops any staged write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q  <= PRIO_A;
      en_q    <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      en_q    <= en_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign reg_enable = en_q;
  assign reg_wdata  = wdata_q;
  assign last_grant = last_q;

`ifdef RF_ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Count contended cycles, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (a.valid && b.valid && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_count = cnt_q;
`else
  assign conflict_count = '0;
`endif

endmodule
